risc: RTL and testbench



---
 rtl/risc.sv | 210 +++++++++++++++++++++
 tb/tb_risc.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/risc.sv
// risc: 16-bit multi-cycle RISC core with unified program/data RAM and a serial program loader.
// Rev 1.0 - initial release.
`default_nettype none

module risc #(
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        PC_rst,
    input  logic [15:0] ext_data,
    input  logic        ext_we,
    output logic [15:0] OutR,
    output logic        done
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [15:0]         r_mem [0:DEPTH-1];
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   r_lp;
    logic [15:0]         r_regs [0:7];
    logic [15:0]         r_ir;
    logic                r_z;
    logic                r_c;
    logic [15:0]         r_out;

    logic [3:0]          w_op;
    logic                w_s;
    logic [2:0]          w_d;
    logic [2:0]          w_a;
    logic [2:0]          w_b;
    logic [1:0]          w_f;
    logic [4:0]          w_i5;
    logic [7:0]          w_i8;
    logic [15:0]         w_ra;
    logic [15:0]         w_rb;
    logic [ADDR_W-1:0]   w_ea;
    logic [ADDR_W-1:0]   w_boff;

    logic [15:0]         w_res;
    logic                w_cout;
    logic                w_rf_we;
    logic                w_flag_we;
    logic                w_mem_we;
    logic                w_pc_ld;
    logic                w_out_we;
    logic                w_halt;
    logic                w_taken;
    logic                w_mem_wr;

    assign w_op   = r_ir[15:12];
    assign w_s    = r_ir[11];
    assign w_d    = r_ir[10:8];
    assign w_a    = r_ir[7:5];
    assign w_b    = r_ir[4:2];
    assign w_f    = r_ir[1:0];
    assign w_i5   = r_ir[4:0];
    assign w_i8   = r_ir[7:0];
    assign w_ra   = r_regs[w_a];
    assign w_rb   = r_regs[w_b];
    assign w_ea   = w_ra[ADDR_W-1:0] + ADDR_W'(w_i5);
    assign w_boff = ADDR_W'($signed(w_i8));

    always_comb begin
        case (r_ir[11:8])
            4'b0000: w_taken = 1'b1;
            4'b0001: w_taken = ~r_z;
            4'b0010: w_taken = r_c;
            4'b0011: w_taken = ~r_c;
            4'b0100: w_taken = r_z;
            default: w_taken = 1'b0;
        endcase
    end

    // Decode/execute for the instruction held in IR; only acted on in EXEC.
    always_comb begin
        w_res     = 16'h0000;
        w_cout    = 1'b0;
        w_rf_we   = 1'b0;
        w_flag_we = 1'b0;
        w_mem_we  = 1'b0;
        w_pc_ld   = 1'b0;
        w_out_we  = 1'b0;
        w_halt    = 1'b0;
        case (w_op)
            4'h0: begin
                w_rf_we = 1'b1;
                if (w_s) begin
                    w_res = {8'h00, w_i8};
                end else begin
                    w_flag_we = 1'b1;
                    case (w_f)
                        2'b00:   {w_cout, w_res} = {1'b0, w_ra} + {1'b0, w_rb};
                        2'b01:   w_res = w_ra & w_rb;
                        2'b10:   {w_cout, w_res} = {1'b0, w_ra} + {1'b0, ~w_rb} + 17'd1;
                        default: w_res = w_ra | w_rb;
                    endcase
                end
            end
            4'h1: begin
                w_rf_we = 1'b1;
                w_res   = r_mem[w_ea];
            end
            4'h2: w_mem_we = 1'b1;
            4'h3: begin
                w_flag_we = 1'b1;
                if (w_s) begin
                    w_rf_we = 1'b1;
                    {w_cout, w_res} = {1'b0, w_ra} + {12'h000, w_i5};
                end else begin
                    // Subtract via two's complement: carry out doubles as "no borrow".
                    {w_cout, w_res} = {1'b0, w_ra} + {1'b0, ~w_rb} + 17'd1;
                end
            end
            4'h5: begin
                w_rf_we = 1'b1;
                w_res   = w_ra;
            end
            4'hC: w_pc_ld = w_taken;
            4'hE: begin
                w_out_we = (w_f == 2'b00);
                w_halt   = (w_f == 2'b01);
            end
            default: ;
        endcase
    end

    assign w_mem_wr = w_mem_we && (r_state == S_EXEC) && !ext_we;

    // RAM contents survive reset so a reset pulse restarts the loaded program.
    always_ff @(posedge clk) begin
        if (ext_we) begin
            r_mem[r_lp] <= ext_data;
        end else if (w_mem_wr) begin
            r_mem[w_ea] <= r_regs[w_d];
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (!ext_we) begin
            case (r_state)
                S_FETCH: w_next_state = S_EXEC;
                S_EXEC:  w_next_state = w_halt ? S_HALT : S_FETCH;
                default: w_next_state = S_HALT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge PC_rst) begin
        if (!PC_rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge PC_rst) begin
        if (!PC_rst) begin
            r_pc  <= '0;
            r_lp  <= '0;
            r_ir  <= 16'h0000;
            r_z   <= 1'b0;
            r_c   <= 1'b0;
            r_out <= 16'h0000;
            for (int k = 0; k < 8; k++) begin
                r_regs[k] <= 16'h0000;
            end
        end else if (ext_we) begin
            r_lp <= r_lp + 1'b1;
        end else begin
            case (r_state)
                S_FETCH: begin
                    r_ir <= r_mem[r_pc];
                    r_pc <= r_pc + 1'b1;
                end
                S_EXEC: begin
                    if (w_rf_we) begin
                        r_regs[w_d] <= w_res;
                    end
                    if (w_flag_we) begin
                        r_z <= (w_res == 16'h0000);
                        r_c <= w_cout;
                    end
                    if (w_pc_ld) begin
                        r_pc <= r_pc + w_boff;
                    end
                    if (w_out_we) begin
                        r_out <= w_ra;
                    end
                end
                default: ;
            endcase
        end
    end

    assign OutR = r_out;
    assign done = (r_state == S_HALT);

endmodule

`default_nettype wire

// File: tb/tb_risc.sv
// tb_risc: table-driven program vectors plus hand-written stall and reset sequences for risc.
// Rev 1.0 - initial release.
`default_nettype none

module tb_risc;

    logic        clk;
    logic        PC_rst;
    logic [15:0] ext_data;
    logic        ext_we;
    logic [15:0] OutR;
    logic        done;

    int n_total;
    int n_pass;

    risc #(.ADDR_W(8)) dut (
        .clk      (clk),
        .PC_rst   (PC_rst),
        .ext_data (ext_data),
        .ext_we   (ext_we),
        .OutR     (OutR),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          start;
        int          n;
        logic [15:0] exp_out;
        int          exp_cyc;
        int          mem_addr;
        logic [15:0] mem_val;
    } vec_t;

    logic [15:0] pool[$];
    vec_t        vecs[6];
    string       names[6];

    task automatic check(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic load_prog(input int start, input int n);
        @(negedge clk);
        PC_rst = 1'b0;
        @(negedge clk);
        PC_rst = 1'b1;
        ext_we = 1'b1;
        for (int i = 0; i < n; i++) begin
            ext_data = pool[start + i];
            @(negedge clk);
        end
        ext_we = 1'b0;
        PC_rst = 1'b0;
        @(negedge clk);
        PC_rst = 1'b1;
    endtask

    task automatic run_to_done(inout int cyc);
        while (cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) return;
        end
        cyc = -1;
    endtask

    logic [15:0] sw[3];
    logic [7:0]  pc0;
    logic [15:0] r0_0;
    int          cyc;

    initial begin
        n_total  = 0;
        n_pass   = 0;
        PC_rst   = 1'b0;
        ext_we   = 1'b0;
        ext_data = 16'h0000;

        // Programs: add @0, loop @5, mem @14, flags @20, carry @28, mov @38
        pool = {16'h0805, 16'h0903, 16'h0204, 16'hE040, 16'hE001,
                16'h0800, 16'h0900, 16'h0B0A, 16'h3921, 16'h0004, 16'h302C, 16'hC1FC, 16'hE000, 16'hE001,
                16'h0D40, 16'h0AAB, 16'h2AA1, 16'h1BA1, 16'hE060, 16'hE001,
                16'h0803, 16'h0905, 16'h0206, 16'hC301, 16'h0C01, 16'hE080, 16'hE040, 16'hE001,
                16'h0901, 16'h0A00, 16'h0346, 16'h3C61, 16'hC201, 16'h0D07, 16'h0665, 16'h07D7, 16'hE0E0, 16'hE001,
                16'h0807, 16'h5100, 16'h3004, 16'hC401, 16'h0A55, 16'h7000, 16'h0328, 16'hE060, 16'hE001};
        vecs[0] = '{start: 0,  n: 5,  exp_out: 16'h0008, exp_cyc: 10, mem_addr: -1, mem_val: 16'h0000};
        vecs[1] = '{start: 5,  n: 9,  exp_out: 16'h0037, exp_cyc: 90, mem_addr: -1, mem_val: 16'h0000};
        vecs[2] = '{start: 14, n: 6,  exp_out: 16'h00AB, exp_cyc: 12, mem_addr: 65, mem_val: 16'h00AB};
        vecs[3] = '{start: 20, n: 8,  exp_out: 16'hFFFE, exp_cyc: 14, mem_addr: -1, mem_val: 16'h0000};
        vecs[4] = '{start: 28, n: 10, exp_out: 16'h0001, exp_cyc: 18, mem_addr: -1, mem_val: 16'h0000};
        vecs[5] = '{start: 38, n: 9,  exp_out: 16'h0007, exp_cyc: 16, mem_addr: -1, mem_val: 16'h0000};
        names   = '{"add", "loop", "mem", "flags", "carry", "mov_cmp"};

        #1;
        check("reset_outr", int'(OutR), 0);
        check("reset_done", int'(done), 0);

        for (int v = 0; v < 6; v++) begin
            load_prog(vecs[v].start, vecs[v].n);
            cyc = 0;
            run_to_done(cyc);
            check({names[v], "_cycles"}, cyc, vecs[v].exp_cyc);
            check({names[v], "_outr"}, int'(OutR), int'(vecs[v].exp_out));
            if (vecs[v].mem_addr >= 0) begin
                check({names[v], "_ram"}, int'(dut.r_mem[vecs[v].mem_addr]), int'(vecs[v].mem_val));
            end
            if (v == 3) begin
                check("flags_r4_skipped", int'(dut.r_regs[4]), 0);
            end
            repeat (5) @(posedge clk);
            #1;
            check({names[v], "_done_held"}, int'(done), 1);
        end

        // Stall the counted loop for three loader writes; the replacement words
        // rebuild the same loop preamble so a later rerun still yields 55.
        sw = '{16'h0002, 16'h0126, 16'h3BEA};
        load_prog(5, 9);
        cyc = 0;
        repeat (20) begin
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        pc0    = dut.r_pc;
        r0_0   = dut.r_regs[0];
        ext_we = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ext_data = sw[k];
            @(posedge clk);
            #1;
            cyc++;
            check("stall_pc_frozen", int'(dut.r_pc), int'(pc0));
            check("stall_r0_frozen", int'(dut.r_regs[0]), int'(r0_0));
            @(negedge clk);
        end
        ext_we = 1'b0;
        run_to_done(cyc);
        check("stall_cycles", cyc, 93);
        check("stall_outr", int'(OutR), 16'h0037);
        for (int k = 0; k < 3; k++) begin
            check("stall_ram_word", int'(dut.r_mem[k]), int'(sw[k]));
        end

        // Asynchronous reset between clock edges, held nine cycles, then rerun.
        @(negedge clk);
        #2;
        PC_rst = 1'b0;
        #1;
        check("async_rst_outr", int'(OutR), 0);
        check("async_rst_done", int'(done), 0);
        repeat (9) begin
            @(posedge clk);
            #1;
            check("rst_hold_outr", int'(OutR), 0);
            check("rst_hold_done", int'(done), 0);
        end
        @(negedge clk);
        PC_rst = 1'b1;
        cyc = 0;
        run_to_done(cyc);
        check("rerun_cycles", cyc, 90);
        check("rerun_outr", int'(OutR), 16'h0037);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
